// File: rtl/mod_n_counter_if.sv
// Direction/count bundle for mod_n_counter. The controller (master) drives the
// direction select; the counter (slave) drives the registered count.
interface mod_n_counter_if #(
  parameter int WIDTH = 4
);
  logic             upordown;
  logic [WIDTH-1:0] count;

  modport master (
    output upordown,
    input  count
  );

  modport slave (
    input  upordown,
    output count
  );
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter: cycles 0..N-1 in the selected direction, wrapping at
// both ends, with asynchronous active-low clear and a registered output.
module mod_n_counter #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  mod_n_counter_if.slave     bus
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             illegal;

  // Out-of-range states exist only when N leaves unused codes; otherwise the
  // check is omitted so no always-false compare is built.
  generate
    if (N < (2 ** WIDTH)) begin : g_range_check
      assign illegal = (count_reg > MAX_VAL);
    end else begin : g_no_range_check
      assign illegal = 1'b0;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (bus.upordown) begin
      if (illegal || (count_reg == MAX_VAL))
        count_next = ZERO_VAL;
      else
        count_next = count_reg + WIDTH'(1);
    end else begin
      if (illegal || (count_reg == ZERO_VAL))
        count_next = MAX_VAL;
      else
        count_next = count_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_reg <= ZERO_VAL;
    else
      count_reg <= count_next;
  end

  assign bus.count = count_reg;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: a default N=10 instance and an N=16 instance,
// each compared against hand-computed count sequences.
module tb_mod_n_counter;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic reset16 = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  mod_n_counter_if #(.WIDTH(4)) bus10 ();
  mod_n_counter_if #(.WIDTH(4)) bus16 ();

  mod_n_counter #(.N(10), .WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus10.slave)
  );

  mod_n_counter #(.N(16), .WIDTH(4)) dut16 (
    .clk   (clk),
    .reset (reset16),
    .bus   (bus16.slave)
  );

  always #10 clk = ~clk;

  task automatic test_reset();
    bus10.upordown = 1'b1;
    bus16.upordown = 1'b1;
    #3;
    reset   = 1'b0;
    reset16 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #5;
      bus10.upordown = ~bus10.upordown;
      tests_run++;
      if (bus10.count !== 4'd0) begin
        tests_failed++;
        $display("FAIL reset_hold t=%0t count=%0d expected=0", $time, bus10.count);
      end
    end
    tests_run++;
    if (bus16.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset16 count=%0d expected=0", bus16.count);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_down_wrap();
    int exp_seq [10] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    @(posedge clk); #1;
    bus10.upordown = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus10.count !== 4'(exp_seq[i])) begin
        tests_failed++;
        $display("FAIL down_wrap step=%0d count=%0d expected=%0d", i, bus10.count, exp_seq[i]);
      end else
        $display("[TB] down step %0d count=%0d", i, bus10.count);
    end
  endtask

  task automatic test_up_wrap();
    int exp_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    bus10.upordown = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus10.count !== 4'(exp_seq[i])) begin
        tests_failed++;
        $display("FAIL up_wrap step=%0d count=%0d expected=%0d", i, bus10.count, exp_seq[i]);
      end else
        $display("[TB] up step %0d count=%0d", i, bus10.count);
    end
  endtask

  // Starts at 2 counting up; reverses at 5 and again at 3, ends at 7.
  task automatic test_reversal();
    int exp_seq [9] = '{3, 4, 5, 4, 3, 4, 5, 6, 7};
    int dir_seq [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      bus10.upordown = dir_seq[i][0];
      @(posedge clk); #1;
      tests_run++;
      if (bus10.count !== 4'(exp_seq[i])) begin
        tests_failed++;
        $display("FAIL reversal step=%0d count=%0d expected=%0d", i, bus10.count, exp_seq[i]);
      end else
        $display("[TB] reversal step %0d dir=%0d count=%0d", i, dir_seq[i], bus10.count);
    end
  endtask

  task automatic test_async_reset();
    tests_run++;
    if (bus10.count !== 4'd7) begin
      tests_failed++;
      $display("FAIL async_pre count=%0d expected=7", bus10.count);
    end
    #5;
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus10.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_clear count=%0d expected=0", bus10.count);
    end else
      $display("[TB] async clear at t=%0t count=0", $time);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus10.count !== 4'd0) begin
        tests_failed++;
        $display("FAIL async_hold step=%0d count=%0d expected=0", i, bus10.count);
      end
    end
    bus10.upordown = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus10.count !== 4'd9) begin
      tests_failed++;
      $display("FAIL async_release count=%0d expected=9", bus10.count);
    end else
      $display("[TB] release down count=%0d", bus10.count);
  endtask

  // Alternating direction every edge across the 9<->0 wrap point.
  task automatic test_back_to_back();
    int exp_seq [4] = '{0, 9, 0, 9};
    int dir_seq [4] = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      bus10.upordown = dir_seq[i][0];
      @(posedge clk); #1;
      tests_run++;
      if (bus10.count !== 4'(exp_seq[i])) begin
        tests_failed++;
        $display("FAIL back_to_back step=%0d count=%0d expected=%0d", i, bus10.count, exp_seq[i]);
      end else
        $display("[TB] toggle step %0d dir=%0d count=%0d", i, dir_seq[i], bus10.count);
    end
  endtask

  task automatic test_param_n16();
    reset16 = 1'b0;
    #1;
    tests_run++;
    if (bus16.count !== 4'd0) begin
      tests_failed++;
      $display("FAIL n16_start count=%0d expected=0", bus16.count);
    end
    bus16.upordown = 1'b1;
    reset16 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus16.count !== 4'(i % 16)) begin
        tests_failed++;
        $display("FAIL n16_up step=%0d count=%0d expected=%0d", i, bus16.count, i % 16);
      end else
        $display("[TB] n16 up step %0d count=%0d", i, bus16.count);
    end
    bus16.upordown = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus16.count !== 4'd15) begin
      tests_failed++;
      $display("FAIL n16_down count=%0d expected=15", bus16.count);
    end else
      $display("[TB] n16 down count=%0d", bus16.count);
  endtask

  initial begin
    test_reset();
    test_down_wrap();
    test_up_wrap();
    test_reversal();
    @(negedge clk);
    test_async_reset();
    test_back_to_back();
    test_param_n16();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
